// File: rtl/fifo_pkg.sv
// Shared types for the dual-clock FIFO pointer logic.
// Holds the default address width, the pointer/address types, the launch-side
// state encoding and the grouping of next-pointer wires.
package fifo_pkg;

    localparam int ADDR_W = 3;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   ptr_t;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } ptr_launch_state_e;

    // Pre-computed successor pointer in both encodings, loaded together on a transfer.
    typedef struct packed {
        ptr_t bin;
        ptr_t gray;
    } next_ptr_s;

endpackage

// File: rtl/fifo_ptr_launch_bin2gray.sv
// Binary to reflected-Gray converter, purely combinational.
module bin2gray #(
    parameter int W = 4
) (
    input  logic [W-1:0] bin_i,
    output logic [W-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/fifo_ptr_launch.sv
// Launch-side pointer controller for one port of the dual-clock FIFO.
// Accepts requests with a valid/ready handshake, advances a wrap-bit binary
// pointer, drives the RAM address/enable and publishes a registered Gray
// pointer for the remote synchronizer.
// Optional build macro: FIFO_PTR_LAUNCH_CNT_EN adds a saturating 16-bit
// transfer counter (xfer_cnt_o) with a synchronous clear (cnt_clr_i).
// ADDR_W must match fifo_pkg::ADDR_W because the internal types come from the package.
module fifo_ptr_launch #(
    parameter int ADDR_W   = fifo_pkg::ADDR_W,
    parameter int HOLD_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              block_i,
`ifdef FIFO_PTR_LAUNCH_CNT_EN
    input  logic              cnt_clr_i,
    output logic [15:0]       xfer_cnt_o,
`endif
    output logic              rdy_o,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [ADDR_W:0]   ptr_bin_o,
    output logic [ADDR_W:0]   ptr_gray_o,
    output logic              err_o
);

    import fifo_pkg::*;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);

    ptr_launch_state_e state_q, state_d;
    logic [3:0]        hold_cnt_q;
    ptr_t              ptr_bin_q;
    ptr_t              ptr_gray_q;
    logic              err_q;
    ptr_t              bin_inc;
    ptr_t              gray_inc;
    next_ptr_s         nxt;
    addr_t             addr;
    logic              xfer;

    // Successor pointer; the Gray form is taken from the next value so the
    // registered Gray output is loaded directly and never passes through logic.
    assign bin_inc = ptr_bin_q + 1'b1;

    bin2gray #(
        .W (ADDR_W + 1)
    ) u_bin2gray (
        .bin_i  (bin_inc),
        .gray_o (gray_inc)
    );

    assign nxt  = '{bin: bin_inc, gray: gray_inc};
    assign addr = ptr_bin_q[ADDR_W-1:0];
    assign xfer = req_i & rdy_o;

    // Next-state and ready decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        rdy_o   = 1'b0;
        case (state_q)
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) state_d = RUN;
            end
            RUN: begin
                rdy_o = ~block_i;
                if (req_i && block_i) state_d = ERR;
            end
            ERR: begin
                rdy_o = ~block_i;
            end
            default: state_d = HOLD;
        endcase
    end

    // State register and post-reset hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q    <= HOLD;
            hold_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == HOLD) hold_cnt_q <= hold_cnt_q + 1'b1;
        end
    end

    // Binary and Gray pointers advance together on an accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_bin_q  <= '0;
            ptr_gray_q <= '0;
        end else if (xfer) begin
            ptr_bin_q  <= nxt.bin;
            ptr_gray_q <= nxt.gray;
        end
    end

    // Sticky error: a request seen while blocked outside the hold window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q != HOLD && req_i && block_i) begin
            err_q <= 1'b1;
        end
    end

`ifdef FIFO_PTR_LAUNCH_CNT_EN
    logic [15:0] xfer_cnt_q;

    // Saturating transfer counter; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt_q <= '0;
        end else if (cnt_clr_i) begin
            xfer_cnt_q <= '0;
        end else if (xfer && xfer_cnt_q != 16'hFFFF) begin
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
        end
    end

    assign xfer_cnt_o = xfer_cnt_q;
`endif

    assign mem_en_o   = xfer;
    assign mem_addr_o = addr;
    assign ptr_bin_o  = ptr_bin_q;
    assign ptr_gray_o = ptr_gray_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_fifo_ptr_launch.sv
// Self-checking bench for fifo_ptr_launch: directed sequences, a stimulus
// table and a randomized run against a transfer-count reference model.
// Counter checks are compiled only with FIFO_PTR_LAUNCH_CNT_EN.
module tb_fifo_ptr_launch;

    localparam int ADDR_W   = 3;
    localparam int HOLD_CYC = 3;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_i = 1'b0;
    logic              block_i = 1'b0;
    logic              rdy_o;
    logic              mem_en_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [ADDR_W:0]   ptr_bin_o;
    logic [ADDR_W:0]   ptr_gray_o;
    logic              err_o;
`ifdef FIFO_PTR_LAUNCH_CNT_EN
    logic              cnt_clr_i = 1'b0;
    logic [15:0]       xfer_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: cycles since reset release, transfers taken, sticky error.
    int m_age = 0;
    int m_ptr = 0;
    int m_cnt = 0;
    bit m_err = 1'b0;

    fifo_ptr_launch #(
        .ADDR_W   (ADDR_W),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .block_i    (block_i),
`ifdef FIFO_PTR_LAUNCH_CNT_EN
        .cnt_clr_i  (cnt_clr_i),
        .xfer_cnt_o (xfer_cnt_o),
`endif
        .rdy_o      (rdy_o),
        .mem_en_o   (mem_en_o),
        .mem_addr_o (mem_addr_o),
        .ptr_bin_o  (ptr_bin_o),
        .ptr_gray_o (ptr_gray_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray_of(input int p);
        return p ^ (p >> 1);
    endfunction

    // Assert reset (asynchronously, no edge in between), check cleared outputs, release.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_ptr_bin", 32'(ptr_bin_o), 0);
        check("rst_ptr_gray", 32'(ptr_gray_o), 0);
        check("rst_rdy", 32'(rdy_o), 0);
        check("rst_err", 32'(err_o), 0);
`ifdef FIFO_PTR_LAUNCH_CNT_EN
        check("rst_cnt", 32'(xfer_cnt_o), 0);
`endif
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_age = 0;
        m_ptr = 0;
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    // One clock: drive at negedge, compare all outputs to the model, then advance the model.
    task automatic cycle(input logic req, input logic blk, input logic clr, output logic rdy_s);
        bit exp_rdy;
        bit running;
        @(negedge clk);
        req_i   = req;
        block_i = blk;
`ifdef FIFO_PTR_LAUNCH_CNT_EN
        cnt_clr_i = clr;
`endif
        #1;
        running = (m_age >= HOLD_CYC);
        exp_rdy = running && !blk;
        check("rdy", 32'(rdy_o), 32'(exp_rdy));
        check("mem_en", 32'(mem_en_o), 32'(exp_rdy && req));
        check("mem_addr", 32'(mem_addr_o), m_ptr % DEPTH);
        check("ptr_bin", 32'(ptr_bin_o), m_ptr);
        check("ptr_gray", 32'(ptr_gray_o), gray_of(m_ptr));
        check("err", 32'(err_o), 32'(m_err));
`ifdef FIFO_PTR_LAUNCH_CNT_EN
        check("xfer_cnt", 32'(xfer_cnt_o), m_cnt);
`endif
        rdy_s = rdy_o;
        @(posedge clk);
        #1;
        if (clr) m_cnt = 0;
        else if (exp_rdy && req && m_cnt < 65535) m_cnt++;
        if (exp_rdy && req) m_ptr = (m_ptr + 1) % (2 * DEPTH);
        if (running && req && blk) m_err = 1'b1;
        if (m_age < HOLD_CYC) m_age++;
    endtask

    typedef struct {
        logic req;
        logic blk;
        logic exp_rdy;
        int   exp_ptr;
        logic exp_err;
    } vec_t;

    initial begin
        vec_t        vecs[10];
        logic        rdy_s;
        logic [ADDR_W:0] prev_gray;

        // Blocked/unblocked alternation with the request held high.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 2, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 2, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 3, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 3, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 4, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 4, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 5, 1'b1};

        @(posedge clk);
        #1;
        req_i = 1'b1;
        do_reset();

        // Reset release with a pending request: ready low for HOLD_CYC cycles.
        for (int i = 0; i < HOLD_CYC; i++) begin
            cycle(1'b1, 1'b0, 1'b0, rdy_s);
            check("hold_rdy", 32'(rdy_s), 0);
        end
        cycle(1'b1, 1'b0, 1'b0, rdy_s);
        check("first_xfer_rdy", 32'(rdy_s), 1);
        check("first_ptr_bin", 32'(ptr_bin_o), 1);
        check("first_ptr_gray", 32'(ptr_gray_o), 32'b0001);

        // Full lap of back-to-back transfers from zero.
        do_reset();
        for (int i = 0; i < HOLD_CYC; i++) cycle(1'b0, 1'b0, 1'b0, rdy_s);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            prev_gray = ptr_gray_o;
            cycle(1'b1, 1'b0, 1'b0, rdy_s);
            check("gray_one_bit", 32'($countones(ptr_gray_o ^ prev_gray)), 1);
            if (i == DEPTH - 1) begin
                check("gray_at_8", 32'(ptr_gray_o), 32'b1100);
                check("addr_wrap", 32'(mem_addr_o), 0);
            end
        end
        check("lap_ptr_bin", 32'(ptr_bin_o), 0);

        // Single blocked request: nothing accepted, error becomes sticky.
        cycle(1'b1, 1'b1, 1'b0, rdy_s);
        check("blk_rdy", 32'(rdy_s), 0);
        check("blk_ptr_held", 32'(ptr_bin_o), 0);
        check("blk_err_set", 32'(err_o), 1);
        cycle(1'b1, 1'b0, 1'b0, rdy_s);
        cycle(1'b0, 1'b0, 1'b0, rdy_s);
        check("err_sticky", 32'(err_o), 1);
        check("err_state_xfer", 32'(ptr_bin_o), 1);

        // Table: block toggling every cycle under a continuous request.
        do_reset();
        for (int i = 0; i < HOLD_CYC; i++) cycle(1'b0, 1'b0, 1'b0, rdy_s);
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].req, vecs[i].blk, 1'b0, rdy_s);
            check("tbl_rdy", 32'(rdy_s), 32'(vecs[i].exp_rdy));
            check("tbl_ptr", 32'(ptr_bin_o), 32'(vecs[i].exp_ptr));
            check("tbl_err", 32'(err_o), 32'(vecs[i].exp_err));
        end

        // Asynchronous reset mid-cycle at pointer 5, requests ignored in HOLD.
        do_reset();
        for (int i = 0; i < HOLD_CYC; i++) cycle(1'b0, 1'b0, 1'b0, rdy_s);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, rdy_s);
        check("pre_rst_ptr", 32'(ptr_bin_o), 5);
        #2;
        do_reset();
        for (int i = 0; i < HOLD_CYC; i++) begin
            cycle(1'b1, 1'b1, 1'b0, rdy_s);
            check("rehold_rdy", 32'(rdy_s), 0);
        end
        check("hold_no_err", 32'(err_o), 0);
        check("hold_no_move", 32'(ptr_bin_o), 0);

        // Randomized traffic against the model, with occasional resets.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            cycle(1'(($urandom % 4) != 0), 1'(($urandom % 4) == 0), 1'b0, rdy_s);
        end

`ifdef FIFO_PTR_LAUNCH_CNT_EN
        do_reset();
        for (int i = 0; i < HOLD_CYC; i++) cycle(1'b0, 1'b0, 1'b0, rdy_s);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, rdy_s);
        check("cnt_20", 32'(xfer_cnt_o), 20);
        cycle(1'b1, 1'b0, 1'b1, rdy_s);
        check("cnt_clr", 32'(xfer_cnt_o), 0);
        @(negedge clk);
        force dut.xfer_cnt_q = 16'hFFFF;
        #1;
        release dut.xfer_cnt_q;
        m_cnt = 65535;
        cycle(1'b1, 1'b0, 1'b0, rdy_s);
        check("cnt_sat", 32'(xfer_cnt_o), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_ptr_launch.md
Name: fifo_ptr_launch

Overview:
- Launch-side pointer controller for one port of the dual-clock FIFO; one instance on the write side and one on the read side.
- Accepts push/pop requests with a valid/ready handshake and advances a binary pointer that carries a wrap bit.
- Drives the RAM address and enable.
- Publishes a registered, glitch-free Gray-coded pointer for the opposite domain's synchronizer and comparator, which return the blocking flag (full or empty) to this block.

Parameters:
- ADDR_W, 3, RAM address width; depth = 2**ADDR_W; the pointer is ADDR_W+1 bits.
- HOLD_CYC, 3, cycles ready stays low after reset release so the remote synchronizer settles; legal range 1..15.

Ports:
- clk  in  1  port-domain clock.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  1  push or pop request (valid).
- block_i  in  1  full or empty flag from the remote compare path; level-sensitive.
- rdy_o  out  1  request can be accepted this cycle.
- mem_en_o  out  1  RAM enable = req_i & rdy_o (combinational).
- mem_addr_o  out  ADDR_W  low ADDR_W bits of the binary pointer.
- ptr_bin_o  out  ADDR_W+1  binary pointer, wrap bit in the MSB.
- ptr_gray_o  out  ADDR_W+1  registered Gray code of ptr_bin_o.
- err_o  out  1  sticky: a request arrived while blocked.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - ptr_bin_o = 0, ptr_gray_o = 0, err_o = 0, rdy_o = 0.
  - State = HOLD, hold counter = 0.
- State machine (3 states, encoded in package enum):
  - HOLD:
    - rdy_o = 0; hold counter increments every cycle.
    - When counter == HOLD_CYC-1 -> RUN on the next edge.
    - Requests in HOLD are ignored: no error, no pointer change.
  - RUN:
    - rdy_o = ~block_i.
    - Transfer when req_i & rdy_o: ptr_bin <= ptr_bin + 1, modulo 2**(ADDR_W+1). The wrap bit toggles when the low bits go from all-ones to 0.
    - ptr_gray <= bin2gray(ptr_bin + 1) on the same edge, so the Gray output changes exactly one bit per transfer and has no combinational path.
    - req_i & block_i -> err_o <= 1 and state -> ERR.
  - ERR:
    - Identical to RUN for transfers; err_o stays 1.
    - Only rst clears it (no exit to RUN).
- Latency:
  - Pointer and Gray update 1 cycle after an accepted request.
  - mem_addr_o shows the pre-increment address during the accepting cycle.
- Boundaries:
  - block_i rising in the same cycle as req_i: not accepted, pointer held, error set.
  - Continuous requests for 2**(ADDR_W+1) cycles return the pointer to 0, with exactly one Gray bit changing per edge, including the wrap.
  - Reset asserted mid-transfer: pointer returns to 0 immediately and the HOLD sequence restarts after release.

Optional Feature:
- Macro FIFO_PTR_LAUNCH_CNT_EN.
- When defined:
  - Adds output xfer_cnt_o, 16 bits: total accepted transfers since reset, saturating at 16'hFFFF.
  - Adds input cnt_clr_i, 1 bit: synchronous clear with priority over increment.
- When undefined: neither port nor any counter logic exists, and behaviour is otherwise identical.

Decomposition:
- fifo_pkg:
  - ADDR_W constant.
  - addr_t (ADDR_W bits) and ptr_t (ADDR_W+1 bits).
  - ptr_launch_state_e {HOLD, RUN, ERR}.
  - Struct grouping the internal next-pointer and next-Gray wires.
- The existing bin2gray module is instantiated as the one sub-module, on the next-pointer value.

Test Plan:
- Reset release with req_i = 1, block_i = 0 -> rdy_o = 0 for exactly 3 cycles; first transfer on cycle 4; ptr_bin_o = 1 and ptr_gray_o = 4'b0001 one cycle later.
- 16 back-to-back transfers, block_i = 0:
  - ptr_bin_o steps 0..15 then back to 0.
  - The checker confirms exactly one ptr_gray_o bit toggles per edge; 7 -> 8 gives Gray 0100 -> 1100.
  - mem_addr_o wraps 7 -> 0.
- In RUN, block_i = 1 with req_i = 1 for one cycle -> rdy_o = 0, mem_en_o = 0, pointer unchanged, err_o = 1 next cycle and stays 1 after block_i drops.
- block_i toggling every cycle with req_i held high for 10 cycles -> pointer advances only on the 5 unblocked cycles; err_o set after the first blocked request.
- rst pulsed asynchronously mid-cycle at ptr_bin_o = 5 -> outputs 0 before the next edge; HOLD repeats for 3 cycles.
- With FIFO_PTR_LAUNCH_CNT_EN:
  - 20 transfers -> xfer_cnt_o = 20.
  - cnt_clr_i together with a transfer -> xfer_cnt_o = 0.
  - Counter preforced to 16'hFFFF stays at 16'hFFFF after a further transfer.
